// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: mode encodings and the
// nominal 640x480 active area.
package vga_pkg;

    localparam logic [2:0] MODE_HSTRIPE = 3'd0;
    localparam logic [2:0] MODE_VSTRIPE = 3'd1;
    localparam logic [2:0] MODE_CHECK   = 3'd2;
    localparam logic [2:0] MODE_BARS    = 3'd3;
    localparam logic [2:0] MODE_SCROLL  = 3'd4;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

endpackage

// File: rtl/vga_bar_counter.sv
// Colour-bar position tracker. Splits the active line into 8 equal bars and
// reports which bar the pixel currently on hc belongs to. The registers hold
// the position of the last accepted pixel; the output is the position of the
// pixel being presented now, so bar 0 is valid on hc==0 without a lag.
module vga_bar_counter #(
    parameter int H_ACTIVE = 640,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          pix_en,
    input  logic [CW-1:0] hc,
    output logic [2:0]    bar_idx
);
    import vga_pkg::*;

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int PXW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [PXW-1:0] bar_px_q, bar_px_d;
    logic [2:0]     bar_idx_q, bar_idx_d;

    // Position of the presented pixel: clear on line start, else step one
    // pixel past the stored one, bumping the bar index (saturating at 7).
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (hc == '0) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (bar_px_q == PXW'(BAR_W - 1)) begin
            bar_px_d  = '0;
            bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
        end else begin
            bar_px_d  = bar_px_q + PXW'(1);
        end
    end

    // Commit the position only when the pixel is actually accepted.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else if (pix_en) begin
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign bar_idx = bar_idx_d;

endmodule

// File: rtl/vga_pattern_gen.sv
// Registered VGA test-pattern generator. Mode is latched at frame start; the
// frame-start pixel itself still renders with the previous mode. Colours
// appear one enabled pixel after hc/vc are presented.
module vga_pattern_gen #(
    parameter int RW       = 3,
    parameter int GW       = 3,
    parameter int BW       = 2,
    parameter int CW       = 10,
    parameter int SHIFT    = 4,
    parameter int H_ACTIVE = 640
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          pix_en,
    input  logic [CW-1:0] hc,
    input  logic [CW-1:0] vc,
    input  logic          vidon,
    input  logic [2:0]    mode,
    output logic [RW-1:0] red,
    output logic [GW-1:0] green,
    output logic [BW-1:0] blue,
    output logic          frame_start
);
    import vga_pkg::*;

    logic          fs;
    logic [2:0]    mode_q;
    logic [7:0]    frame_cnt_q;
    logic [2:0]    bar_idx;
    logic [2:0]    bar_col;
    logic          scroll_bit;
    logic          s;
    logic [RW-1:0] red_d,   red_q;
    logic [GW-1:0] green_d, green_q;
    logic [BW-1:0] blue_d,  blue_q;
    logic          frame_start_q;

    assign fs = pix_en && (hc == '0) && (vc == '0);

    vga_bar_counter #(
        .H_ACTIVE (H_ACTIVE),
        .CW       (CW)
    ) u_bar (
        .clk     (clk),
        .clr_n   (clr_n),
        .pix_en  (pix_en),
        .hc      (hc),
        .bar_idx (bar_idx)
    );

    // Bars run white..black, i.e. the colour code counts down from 7.
    assign bar_col = 3'd7 - bar_idx;

    // Scroll phase: bit SHIFT of (vc + frame_cnt) modulo 2^CW.
    assign scroll_bit = |((vc + CW'(frame_cnt_q)) & (CW'(1) << SHIFT));

    // Pattern select from the latched mode; blanking overrides everything.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        s       = 1'b0;
        case (mode_q)
            MODE_HSTRIPE: begin
                s       = vc[SHIFT];
                red_d   = {RW{s}};
                green_d = {GW{~s}};
            end
            MODE_VSTRIPE: begin
                s       = hc[SHIFT];
                red_d   = {RW{s}};
                blue_d  = {BW{~s}};
            end
            MODE_CHECK: begin
                s       = hc[SHIFT] ^ vc[SHIFT];
                red_d   = {RW{s}};
                green_d = {GW{s}};
                blue_d  = {BW{s}};
            end
            MODE_BARS: begin
                red_d   = {RW{bar_col[2]}};
                green_d = {GW{bar_col[1]}};
                blue_d  = {BW{bar_col[0]}};
            end
            MODE_SCROLL: begin
                s       = scroll_bit;
                red_d   = {RW{s}};
                green_d = {GW{~s}};
            end
            default: ;
        endcase
        if (!vidon) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end
    end

    // Mode and frame counter advance only on the frame-start pixel.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mode_q      <= MODE_HSTRIPE;
            frame_cnt_q <= '0;
        end else if (fs) begin
            mode_q      <= mode;
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    // Colour output register, held while the pixel enable is low.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (pix_en) begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    // Frame-start pulse is a single clk wide regardless of pix_en cadence.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) frame_start_q <= 1'b0;
        else        frame_start_q <= fs;
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign frame_start = frame_start_q;

endmodule
